// File: rtl/add_n_seq_ctrl_if.sv
// Stream bundle for add_n_seq_ctrl: beat input, frame-total output, config and status.
// The slave modport is the controller side; the master modport is the producer/consumer side.
interface add_n_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int LW = 4
);
  logic [LW-1:0]   cfg_len;
  logic            in_valid;
  logic            in_ready;
  logic [DW*N-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_sum;
  logic            busy;

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/add_n_seq_ctrl.sv
// Frame-accumulation controller: each beat is reduced by a shared N-input adder and
// folded into a running total that is presented once the configured beat count is reached.

module add_N #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic [DW*N-1:0] in_data,
  output logic [DW-1:0]   sum
);
  logic [DW-1:0] part [N+1];

  assign part[0] = '0;

  // Ripple chain of wrapping adds; the result is the N-word sum modulo 2^DW.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_add
      assign part[gi+1] = part[gi] + in_data[gi*DW +: DW];
    end
  endgenerate

  assign sum = part[N];
endmodule

module add_n_seq_ctrl #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  add_n_seq_ctrl_if.slave      bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] grp;
  logic [LW-1:0] len_eff;
  logic          beat;

  add_N #(.N(N), .DW(DW)) u_add (
    .in_data (bus.in_data),
    .sum     (grp)
  );

  assign len_eff = (bus.cfg_len == '0) ? LW'(1) : bus.cfg_len;
  assign beat    = bus.in_valid && (state_q != HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= LW'(1);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = len_eff;
          acc_d   = grp;
          cnt_d   = LW'(1);
          state_d = (len_eff == LW'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + grp;
          cnt_d = cnt_q + LW'(1);
          // Frame length was latched on the first beat, so cfg_len is not consulted here.
          if ((cnt_q + LW'(1)) == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q != HOLD);
    bus.out_valid = (state_q == HOLD);
    bus.busy      = (state_q != IDLE);
    bus.out_sum   = acc_q;
  end
endmodule

// File: tb/tb_add_n_seq_ctrl.sv
// Self-checking bench for add_n_seq_ctrl: directed scenarios plus randomized frames
// checked against a plain-arithmetic frame-sum model.
module tb_add_n_seq_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  add_n_seq_ctrl_if #(.N(N), .DW(DW), .LW(LW)) bus ();

  add_n_seq_ctrl #(.N(N), .DW(DW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int word_sum(input logic [DW*N-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s = s + int'((d >> (DW * i)) & {{(DW*N-DW){1'b0}}, {DW{1'b1}}});
    end
    return s % (1 << DW);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat for one cycle; acc reports whether the block was ready for it.
  task automatic send_beat(input logic [DW*N-1:0] d, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc          = bus.in_ready;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    ok = (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0) &&
         (bus.busy === 1'b0) && (bus.out_sum === 8'd0);
    if (!ok) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_sum=%0d, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b out_sum=%0d",
             bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
  endtask

  task automatic test_basic();
    bit a;
    bus.cfg_len   = 4'd3;
    bus.out_ready = 1'b1;
    send_beat(32'h04030201, a);
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b out_valid=%b, required 1 0", bus.busy, bus.out_valid);
    end
    send_beat(32'h08070605, a);
    send_beat(32'h0a0a0a0a, a);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd76 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: out_valid=%b out_sum=%0d in_ready=%b, required 1 76 0",
               bus.out_valid, bus.out_sum, bus.in_ready);
    end
    $display("basic: out_valid=%b out_sum=%0d", bus.out_valid, bus.out_sum);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_wrap();
    bit a;
    bus.cfg_len   = 4'd2;
    bus.out_ready = 1'b1;
    send_beat(32'h000064c8, a);
    send_beat(32'h000001ff, a);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd44) begin
      errors++;
      $display("FAIL wrap_sum: out_valid=%b out_sum=%0d, required 1 44", bus.out_valid, bus.out_sum);
    end
    $display("wrap: out_sum=%0d", bus.out_sum);
    step();
    bus.cfg_len = 4'd0;
    send_beat(32'h01010101, a);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd4) begin
      errors++;
      $display("FAIL len0_sum: out_valid=%b out_sum=%0d, required 1 4", bus.out_valid, bus.out_sum);
    end
    $display("len0: out_sum=%0d", bus.out_sum);
    step();
  endtask

  task automatic test_backpressure();
    bit a;
    bus.cfg_len   = 4'd1;
    bus.out_ready = 1'b0;
    send_beat(32'h05050505, a);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h01020304;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 8'd20 ||
          bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b out_sum=%0d busy=%b, required 0 1 20 1",
                 i, bus.in_ready, bus.out_valid, bus.out_sum, bus.busy);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd10) begin
      errors++;
      $display("FAIL bp_next: out_valid=%b out_sum=%0d, required 1 10", bus.out_valid, bus.out_sum);
    end
    $display("backpressure: next frame out_sum=%0d", bus.out_sum);
    step();
  endtask

  task automatic test_gaps_cfg();
    bit a;
    logic [31:0] d;
    int exp;
    exp = 0;
    bus.cfg_len   = 4'd4;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      d   = $urandom;
      exp = (exp + word_sum(d)) % 256;
      send_beat(d, a);
      if (b == 0) bus.cfg_len = 4'd1;
      if (b < 3) begin
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_early: beat %0d gap %0d out_valid=%b, required 0", b, g, bus.out_valid);
          end
          step();
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== exp[7:0]) begin
      errors++;
      $display("FAIL gap_sum: out_valid=%b out_sum=%0d, required 1 %0d", bus.out_valid, bus.out_sum, exp);
    end
    $display("gaps: out_sum=%0d expected=%0d", bus.out_sum, exp);
    step();
  endtask

  task automatic test_reset_mid();
    bit a;
    bus.cfg_len   = 4'd4;
    bus.out_ready = 1'b1;
    send_beat($urandom, a);
    send_beat($urandom, a);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_sum !== 8'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b busy=%b out_sum=%0d in_ready=%b, required 0 0 0 1",
               bus.out_valid, bus.busy, bus.out_sum, bus.in_ready);
    end
    for (int b = 0; b < 4; b++) begin
      send_beat(32'h01010101, a);
      if (b < 3) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rst_new_early: beat %0d out_valid=%b, required 0", b, bus.out_valid);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd16) begin
      errors++;
      $display("FAIL rst_new_sum: out_valid=%b out_sum=%0d, required 1 16", bus.out_valid, bus.out_sum);
    end
    $display("reset_mid: new frame out_sum=%0d", bus.out_sum);
    step();
  endtask

  task automatic test_max_len();
    bit a;
    bus.cfg_len   = 4'd15;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 15; b++) begin
      send_beat(32'h01010101, a);
      if (b < 14) begin
        checks++;
        if (bus.out_valid !== 1'b0 || a !== 1'b1) begin
          errors++;
          $display("FAIL max_early: beat %0d out_valid=%b accepted=%b, required 0 1", b, bus.out_valid, a);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'd60) begin
      errors++;
      $display("FAIL max_sum: out_valid=%b out_sum=%0d, required 1 60", bus.out_valid, bus.out_sum);
    end
    $display("max_len: out_sum=%0d", bus.out_sum);
    step();
  endtask

  task automatic test_random();
    bit a;
    logic [31:0] d;
    int cfg, eff, exp, wait_n;
    for (int f = 0; f < 25; f++) begin
      cfg           = $urandom_range(0, 15);
      eff           = (cfg == 0) ? 1 : cfg;
      exp           = 0;
      bus.cfg_len   = 4'(cfg);
      bus.out_ready = 1'b0;
      for (int b = 0; b < eff; b++) begin
        d   = $urandom;
        exp = (exp + word_sum(d)) % 256;
        send_beat(d, a);
        if (b == 0) bus.cfg_len = 4'($urandom_range(0, 15));
        checks++;
        if (a !== 1'b1 || ((b < eff - 1) && bus.out_valid !== 1'b0)) begin
          errors++;
          $display("FAIL rnd_beat: frame %0d beat %0d accepted=%b out_valid=%b", f, b, a, bus.out_valid);
        end
        if (b < eff - 1 && $urandom_range(0, 3) == 0) step();
      end
      wait_n = $urandom_range(0, 3);
      for (int w = 0; w <= wait_n; w++) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== exp[7:0]) begin
          errors++;
          $display("FAIL rnd_sum: frame %0d len %0d out_valid=%b out_sum=%0d, required 1 %0d",
                   f, eff, bus.out_valid, bus.out_sum, exp);
        end
        if (w < wait_n) step();
      end
      $display("random frame %0d: len=%0d out_sum=%0d expected=%0d", f, eff, bus.out_sum, exp);
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_xfer: frame %0d out_valid=%b after transfer, required 0", f, bus.out_valid);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_gaps_cfg();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_n_seq_ctrl.md
# add_N_seq_ctrl

Frame-accumulation controller that sequences a shared N-input combinational adder (`add_N`) over multi-beat frames. Each accepted beat carries N packed DW-bit words; the block sums the beat through one internal `add_N` instance and folds the result into a running accumulator. After a configurable number of beats it presents the frame total on a valid/ready output. It sits between a streaming producer and any consumer that needs per-frame reductions wider than one adder pass.

## Interface
- `N`, 4, words per input beat; passed to the internal `add_N`.
- `DW`, 8, data width of each word, the accumulator and the result.
- `LW`, 4, width of the beat counter and of `cfg_len`.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cfg_len`  input  LW  beats per frame; sampled only on a frame's first accepted beat; 0 is treated as 1.
- `in_valid`  input  1  producer has a beat on `in_data`.
- `in_ready`  output  1  block accepts a beat this cycle.
- `in_data`  input  DW*N  N packed words; word i at bits [(i+1)*DW-1 : i*DW].
- `out_valid`  output  1  `out_sum` holds a completed frame total.
- `out_ready`  input  1  consumer takes the result.
- `out_sum`  output  DW  frame total, modulo 2^DW.
- `busy`  output  1  high in ACCUM or HOLD.

## Operation
- A beat is accepted when `in_valid && in_ready`. The result transfers when `out_valid && out_ready`.
- `grp` is the `add_N` output for `in_data`: the sum of N words mod 2^DW, unsigned. All adds wrap with no saturation and no overflow flag.
- States: IDLE, ACCUM, HOLD.
- IDLE (`in_ready`=1, `out_valid`=0, `busy`=0):
  - On a beat: `len_q` ← max(`cfg_len`,1), `acc` ← `grp`, `cnt` ← 1.
  - Go to HOLD if `len_q` = 1, else go to ACCUM.
- ACCUM (`in_ready`=1, `out_valid`=0, `busy`=1):
  - On a beat: `acc` ← `acc` + `grp`, `cnt` ← `cnt` + 1.
  - If `cnt` + 1 = `len_q`, go to HOLD.
  - With no beat, hold all state. Idle gaps of any length are allowed.
- HOLD (`in_ready`=0, `out_valid`=1, `busy`=1):
  - `out_sum` = `acc`, held stable until transfer.
  - On transfer go to IDLE.
  - `in_valid` is ignored in HOLD. The next frame's first beat is accepted no earlier than the cycle after the transfer.
- `cfg_len` changes during ACCUM or HOLD have no effect on the current frame.
- Max frame length is 2^LW − 1 beats. `cnt` never wraps.
- `out_sum` shows `acc` in every state. It is meaningful only while `out_valid`=1.

## Timing
- Reset values: state=IDLE, `acc`=0, `cnt`=0, `len_q`=1, `in_ready`=1, `out_valid`=0, `out_sum`=0, `busy`=0.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- The adder path `in_data` → `add_N` → `acc` is combinational within one cycle. There is no pipeline register.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- Back-to-back throughput: a len-L frame takes L beat cycles + 1 HOLD cycle when `out_ready` is held high. For L=1 that is one frame per 2 cycles.
- `rst` asserted in any state returns to reset values on the next edge. A partial frame and any pending result are discarded, with no output. `rst` overrides a simultaneous beat or transfer.
- If `out_ready` is already high on HOLD entry, the transfer occurs on the first HOLD cycle.

## Test plan
- N=4, DW=8, `cfg_len`=3. Send beats {1,2,3,4}, {5,6,7,8}, {10,10,10,10}, with `out_ready`=1.
  - `out_valid` rises one cycle after the third beat with `out_sum`=76. `in_ready`=0 for that one cycle, then the block returns to IDLE.
- Wrap-around, `cfg_len`=2. Send beats {200,100,0,0} and {255,1,0,0}.
  - Beat sums are 44 and 0, so `out_sum`=44. `cfg_len`=0 with the single beat {1,1,1,1} gives `out_sum`=4 after 1 beat.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1.
  - `out_sum` stays stable, `in_ready`=0 throughout, and no beat is consumed. On `out_ready`=1 the transfer occurs, and the next beat is accepted the following cycle.
- Gaps and config change, `cfg_len`=4. Insert 3 idle cycles between beats and change `cfg_len` to 1 after the first beat.
  - The frame still completes after 4 beats with the correct total.
- Reset mid-frame: assert `rst` after 2 of 4 beats.
  - The next cycle shows IDLE with `out_valid`=0, `busy`=0, `out_sum`=0. A new frame {1,1,1,1}×4 then yields 16, with no residue from the aborted frame.
- Max length: `cfg_len`=15 with all beats {1,1,1,1}.
  - `out_sum`=60 after exactly 15 accepted beats, with `cnt` not wrapping.
